// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-tick divider, h/v counters, sync generation and test-pattern RGB332 output.
// Optional border overlay is compiled in when the VGA_BORDER_EN macro is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        CLK_100MHz,
  input  logic        Reset_n,
  input  logic [1:0]  Mode,
  input  logic [7:0]  PixelIn,
  output logic        PixelReq,
  output logic [10:0] X,
  output logic [10:0] Y,
  output logic        Active,
  output logic        FrameStart,
  output logic        HSync,
  output logic        VSync,
  output logic [2:0]  Red,
  output logic [2:0]  Green,
  output logic [1:0]  Blue
);

  localparam int HTOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W = H_ACTIVE / 8;

  localparam logic [10:0] H_LAST   = 11'(HTOT - 1);
  localparam logic [10:0] V_LAST   = 11'(VTOT - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0]  r_div;
  logic [10:0] r_hcnt;
  logic [10:0] r_vcnt;
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic        r_active;
  logic        r_pixreq;
  logic        r_frame_start;
  logic [1:0]  r_mode;
  logic        r_hsync;
  logic        r_vsync;
  logic [7:0]  r_rgb;

  logic        w_tick;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_active_now;
  logic        w_origin;
  logic [2:0]  w_bar_idx;
  logic [7:0]  w_bar_rgb;
  logic [7:0]  w_pixel;

  assign w_tick       = (r_div == DIV_LAST);
  assign w_h_wrap     = (r_hcnt == H_LAST);
  assign w_v_wrap     = (r_vcnt == V_LAST);
  assign w_active_now = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_origin     = (r_hcnt == 11'd0) && (r_vcnt == 11'd0);

  always_ff @(posedge CLK_100MHz) begin
    if (!Reset_n) begin
      r_div <= 4'd0;
    end else if (w_tick) begin
      r_div <= 4'd0;
    end else begin
      r_div <= r_div + 4'd1;
    end
  end

  always_ff @(posedge CLK_100MHz) begin
    if (!Reset_n) begin
      r_hcnt <= 11'd0;
      r_vcnt <= 11'd0;
    end else if (w_tick) begin
      r_hcnt <= w_h_wrap ? 11'd0 : r_hcnt + 11'd1;
      if (w_h_wrap) begin
        r_vcnt <= w_v_wrap ? 11'd0 : r_vcnt + 11'd1;
      end
    end
  end

  // Request/response: PixelReq pulses for one clock on the tick that presents X/Y;
  // the caller holds PixelIn for that pixel so it is sampled on the following tick.
  always_ff @(posedge CLK_100MHz) begin
    if (!Reset_n) begin
      r_x           <= 11'd0;
      r_y           <= 11'd0;
      r_active      <= 1'b0;
      r_pixreq      <= 1'b0;
      r_frame_start <= 1'b0;
      r_mode        <= 2'd0;
    end else begin
      r_pixreq      <= w_tick && w_active_now;
      r_frame_start <= w_tick && w_origin;
      if (w_tick) begin
        r_x      <= r_hcnt;
        r_y      <= r_vcnt;
        r_active <= w_active_now;
        if (w_origin) begin
          r_mode <= Mode;
        end
      end
    end
  end

  always_comb begin
    w_bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (r_x >= 11'(k * BAR_W)) begin
        w_bar_idx = 3'(k);
      end
    end
  end

  always_comb begin
    w_bar_rgb = 8'h00;
    case (w_bar_idx)
      3'd0:    w_bar_rgb = 8'hFF;
      3'd1:    w_bar_rgb = 8'hFC;
      3'd2:    w_bar_rgb = 8'h1F;
      3'd3:    w_bar_rgb = 8'h1C;
      3'd4:    w_bar_rgb = 8'hE3;
      3'd5:    w_bar_rgb = 8'hE0;
      3'd6:    w_bar_rgb = 8'h03;
      default: w_bar_rgb = 8'h00;
    endcase
  end

  // Pattern is evaluated on the previous tick's coordinates, one tick behind X/Y.
  always_comb begin
    w_pixel = 8'h00;
    case (r_mode)
      2'd0:    w_pixel = 8'h00;
      2'd1:    w_pixel = w_bar_rgb;
      2'd2:    w_pixel = (r_x[5] ^ r_y[5]) ? 8'hFF : 8'h00;
      default: w_pixel = PixelIn;
    endcase
`ifdef VGA_BORDER_EN
    if ((r_x == 11'd0) || (r_x == H_ACT - 11'd1) || (r_y == 11'd0) || (r_y == V_ACT - 11'd1)) begin
      w_pixel = 8'hFF;
    end
`endif
  end

  always_ff @(posedge CLK_100MHz) begin
    if (!Reset_n) begin
      r_hsync <= ~HS_POL;
      r_vsync <= ~VS_POL;
      r_rgb   <= 8'h00;
    end else if (w_tick) begin
      r_hsync <= ((r_x >= HS_START) && (r_x <= HS_END)) ? HS_POL : ~HS_POL;
      r_vsync <= ((r_y >= VS_START) && (r_y <= VS_END)) ? VS_POL : ~VS_POL;
      r_rgb   <= r_active ? w_pixel : 8'h00;
    end
  end

  assign PixelReq   = r_pixreq;
  assign X          = r_x;
  assign Y          = r_y;
  assign Active     = r_active;
  assign FrameStart = r_frame_start;
  assign HSync      = r_hsync;
  assign VSync      = r_vsync;
  assign Red        = r_rgb[7:5];
  assign Green      = r_rgb[4:2];
  assign Blue       = r_rgb[1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster: per-clock expected outputs from an
// arithmetic reference model, plus frame-period and sync-width checks.
module tb_vga_timing_gen;

  localparam int HA = 80, HFP = 4, HSW = 6, HBP = 6;
  localparam int VA = 40, VFP = 2, VSW = 2, VBP = 3;
  localparam int DIV = 2;
  localparam bit HP = 1'b1;
  localparam bit VP = 1'b0;
  localparam int HTOT = HA + HFP + HSW + HBP;
  localparam int VTOT = VA + VFP + VSW + VBP;
  localparam int FT = HTOT * VTOT;
  localparam int W = 35;

  // clock / reset / DUT
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  mode;
  logic [7:0]  pin;
  logic        pixreq, active, fs, hs, vs;
  logic [10:0] x, y;
  logic [2:0]  red, green;
  logic [1:0]  blue;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .CLK_DIV(DIV), .HS_POL(HP), .VS_POL(VP)
  ) dut (
    .CLK_100MHz(clk), .Reset_n(rst_n), .Mode(mode), .PixelIn(pin),
    .PixelReq(pixreq), .X(x), .Y(y), .Active(active), .FrameStart(fs),
    .HSync(hs), .VSync(vs), .Red(red), .Green(green), .Blue(blue)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int clk_cnt = 0;
  int last_fs = -1;
  int hs_run = -1;

  // reference model state: clocks since release, ticks since release, latched frame mode
  int m_c = 0;
  int m_t = 0;
  logic [1:0] m_mode = 2'd0;
  logic [W-1:0] m_exp;
  logic [1:0] plan [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2};

  function automatic logic [W-1:0] pack(int px, int py, logic pa, logic preq, logic pfs,
                                        logic phs, logic pvs, logic [7:0] prgb);
    return {11'(px), 11'(py), pa, preq, pfs, phs, pvs, prgb};
  endfunction

  function automatic logic [7:0] ref_pixel(logic [1:0] md, int h, int v, logic [7:0] p_in);
    logic [7:0] bars [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
    int idx;
`ifdef VGA_BORDER_EN
    if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) return 8'hFF;
`endif
    case (md)
      2'd0: return 8'h00;
      2'd1: begin
        idx = h / (HA / 8);
        if (idx > 7) idx = 7;
        return bars[idx];
      end
      2'd2: return (((h / 32) + (v / 32)) % 2 == 1) ? 8'hFF : 8'h00;
      default: return p_in;
    endcase
  endfunction

  function automatic bit next_is_frame_tick();
    return rst_n && ((m_c + 1) % DIV == 0) && (m_t % FT == 0);
  endfunction

  // Expected outputs after the coming rising edge, from the raster arithmetic.
  task automatic model_step();
    int p, q, h, v;
    logic a, hsv, vsv;
    logic [7:0] rgb;
    if (!rst_n) begin
      m_c = 0;
      m_t = 0;
      m_exp = pack(0, 0, 1'b0, 1'b0, 1'b0, ~HP, ~VP, 8'h00);
    end else begin
      m_c++;
      if (m_c % DIV == 0) begin
        m_t++;
        q = m_t - 2;
        if (q < 0) begin
          hsv = ~HP; vsv = ~VP; rgb = 8'h00;
        end else begin
          h = q % HTOT;
          v = (q / HTOT) % VTOT;
          hsv = (h >= HA + HFP && h < HA + HFP + HSW) ? HP : ~HP;
          vsv = (v >= VA + VFP && v < VA + VFP + VSW) ? VP : ~VP;
          rgb = (h < HA && v < VA) ? ref_pixel(m_mode, h, v, pin) : 8'h00;
        end
        p = m_t - 1;
        h = p % HTOT;
        v = (p / HTOT) % VTOT;
        a = (h < HA) && (v < VA);
        if (p % FT == 0) m_mode = mode;
        m_exp = pack(h, v, a, a, (p % FT == 0), hsv, vsv, rgb);
      end else begin
        m_exp[11] = 1'b0;
        m_exp[10] = 1'b0;
      end
    end
    exp_q.push_back(m_exp);
  endtask

  // driver: inputs change on the falling edge; Mode is random except on the frame-start tick
  task automatic drive_cycle(input logic rn);
    @(negedge clk);
    rst_n = rn;
    pin = 8'($urandom_range(0, 255));
    if (next_is_frame_tick()) mode = plan[(m_t / FT) % 5];
    else mode = 2'($urandom_range(0, 3));
    model_step();
  endtask

  // monitor: pops one expectation per clock and compares
  initial begin
    logic [W-1:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      clk_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {x, y, active, pixreq, fs, hs, vs, red, green, blue};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs clk=%0d got x=%0d y=%0d act=%b req=%b fs=%b hs=%b vs=%b rgb=%h exp x=%0d y=%0d act=%b req=%b fs=%b hs=%b vs=%b rgb=%h",
                   clk_cnt, got[34:24], got[23:13], got[12], got[11], got[10], got[9], got[8], got[7:0],
                   e[34:24], e[23:13], e[12], e[11], e[10], e[9], e[8], e[7:0]);
        end
        if (!rst_n) begin
          last_fs = -1;
          hs_run = -1;
        end else begin
          if (fs) begin
            if (last_fs >= 0) begin
              n_checks++;
              if (clk_cnt - last_fs != FT * DIV) begin
                n_fail++;
                $display("FAIL frame_period got %0d clocks exp %0d", clk_cnt - last_fs, FT * DIV);
              end
            end
            last_fs = clk_cnt;
          end
          if (hs == HP) begin
            if (hs_run >= 0) hs_run++;
          end else begin
            if (hs_run > 0) begin
              n_checks++;
              if (hs_run != HSW * DIV) begin
                n_fail++;
                $display("FAIL hsync_width got %0d clocks exp %0d", hs_run, HSW * DIV);
              end
            end
            hs_run = 0;
          end
        end
      end
    end
  end

  // stimulus sequence and final report
  initial begin
    rst_n = 1'b0;
    mode = 2'd0;
    pin = 8'h00;
    repeat (10) drive_cycle(1'b0);
    repeat (3 * FT * DIV + 1234) drive_cycle(1'b1);
    repeat (3) drive_cycle(1'b0);
    repeat (2 * FT * DIV + 500) drive_cycle(1'b1);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got %0d pending exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, sets visible pixels per line.
REQ-002 Parameters H_FP, H_SYNC, H_BP, defaults 16/96/48, set horizontal front porch, sync and back porch in pixels.
REQ-003 Parameter V_ACTIVE, default 480, sets visible lines per frame.
REQ-004 Parameters V_FP, V_SYNC, V_BP, defaults 10/2/33, set vertical front porch, sync and back porch in lines.
REQ-005 Parameter CLK_DIV, default 4, sets clock cycles per pixel tick; legal range is 1..16.
REQ-006 Parameters HS_POL and VS_POL, default 0 each, set the asserted sync level; 0 is active-low.
REQ-007 The block SHALL have one clock and a synchronous, active-low reset.
REQ-008 CLK_100MHz  in  1  system clock; all logic on its rising edge.
REQ-009 Reset_n  in  1  synchronous active-low reset.
REQ-010 Mode  in  2  pattern select: 0 black, 1 colour bars, 2 checkerboard, 3 external PixelIn.
REQ-011 PixelIn  in  8  external RGB332 pixel, {R[2:0],G[2:0],B[1:0]}.
REQ-012 PixelReq  out  1  asserts for one clock on the tick that requests the pixel at X/Y.
REQ-013 X, Y  out  11 each  current pixel coordinate; valid while Active is high.
REQ-014 Active  out  1  current counter position lies inside the visible area.
REQ-015 FrameStart  out  1  one-clock pulse on the tick at which the counters are at (0,0).
REQ-016 HSync, VSync  out  1 each  sync outputs.
REQ-017 Red, Green, Blue  out  3/3/2  colour outputs.

Function
REQ-018 The divider SHALL emit a one-clock pixel tick every CLK_DIV clocks; with CLK_DIV=1 a tick occurs on every clock.
REQ-019 Horizontal counter hcnt SHALL advance on each tick over 0..HTOT-1, HTOT=H_ACTIVE+H_FP+H_SYNC+H_BP, and wrap to 0.
REQ-020 Vertical counter vcnt SHALL advance when hcnt wraps, over 0..VTOT-1, and wrap to 0 together with hcnt.
REQ-021 X=hcnt, Y=vcnt, Active=(hcnt<H_ACTIVE && vcnt<V_ACTIVE), and PixelReq=Active&&tick SHALL all be registered and update on the tick.
REQ-022 HSync SHALL be asserted while hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; VSync likewise for vcnt against the V parameters.
REQ-023 HSync, VSync and RGB SHALL lag X/Y/Active by exactly one pixel tick, so PixelIn sampled on the tick after PixelReq aligns with its sync.
REQ-024 Mode SHALL be latched only on the FrameStart tick; a mid-frame change SHALL take effect at the next frame.
REQ-025 Mode 1: 8 bars of H_ACTIVE/8 pixels, in order FF, FC, 1F, 1C, E3, E0, 03, 00 (RGB332).
REQ-026 Mode 2: 32x32 squares, pixel = (X[5]^Y[5]) ? FF : 00.
REQ-027 Mode 3: pixel = PixelIn sampled on the tick after PixelReq.
REQ-028 RGB SHALL be 0 whenever the delayed Active is low (blanking).

Reset
REQ-029 While Reset_n=0 at a clock edge: hcnt, vcnt and the divider SHALL be 0, RGB 0, HSync=~HS_POL, VSync=~VS_POL, Active, PixelReq and FrameStart 0, and the latched Mode 0.
REQ-030 After release, the first tick SHALL occur CLK_DIV clocks later, and the block SHALL restart at (0,0) with FrameStart.
REQ-031 Reset asserted mid-frame SHALL take effect on the next edge, with no partial line emitted afterwards.

Configuration
REQ-032 With VGA_BORDER_EN defined, pixels with X=0, X=H_ACTIVE-1, Y=0 or Y=V_ACTIVE-1 SHALL output FF regardless of Mode.
REQ-033 Without VGA_BORDER_EN, no border logic SHALL exist and output SHALL follow REQ-025..028 only.

Verification
REQ-034 Hold Reset_n low 10 clocks -> HSync=1, VSync=1, RGB=0, X=Y=0, Active=0.
REQ-035 Defaults, free run -> HSync low for 384 clocks out of every 3200 clocks (period 32 us).
REQ-036 Defaults -> VSync low for 2 lines (6400 clocks); FrameStart period 1,680,000 clocks (16.8 ms).
REQ-037 Mode=1 -> at X=0, RGB=7/7/3; at X=80, RGB=7/7/0; at X=639, RGB=0/0/0.
REQ-038 Mode switched 0->2 at Y=100 -> output stays black until the next FrameStart, then shows checkerboard with (32,0) = FF.
REQ-039 VGA_BORDER_EN defined with Mode=0 -> (0,5), (639,5) and (5,479) output FF, and (5,5) outputs 00.
